// File: rtl/stream_mux.sv
// Registered N-channel stream multiplexer with valid/ready handshaking.
// Selection is direct (sel port), fixed priority or round-robin, chosen by MODE.
module stream_mux #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned MODE     = 0,
   parameter int unsigned SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SEL_W-1:0]          out_sel
);

   logic                space;
   logic                grant_any;
   logic [SEL_W-1:0]    grant_idx;
   logic [CHANNELS-1:0] grant_oh;
   logic [WIDTH-1:0]    grant_word;
   logic                xfer;

   function automatic logic [SEL_W-1:0] lowest_idx(input logic [CHANNELS-1:0] v);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
         if (v[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

   assign space = ~out_valid | out_ready;

   generate
      if (MODE == 0) begin : g_direct
         // Out-of-range sel values match no channel, so they grant nothing.
         always_comb begin
            grant_any = 1'b0;
            grant_idx = '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
               if (sel == SEL_W'(i) && in_valid[i]) begin
                  grant_any = 1'b1;
                  grant_idx = SEL_W'(i);
               end
            end
         end
      end else if (MODE == 1) begin : g_prio
         always_comb begin
            grant_any = |in_valid;
            grant_idx = lowest_idx(in_valid);
         end
      end else begin : g_rr
         logic [SEL_W-1:0]    ptr_q;
         logic [SEL_W-1:0]    ptr_d;
         logic [CHANNELS-1:0] upper_mask;
         logic [CHANNELS-1:0] upper_req;

         // Requests at or above ptr win first; otherwise wrap to the lowest request.
         always_comb begin
            upper_mask = '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
               upper_mask[i] = (SEL_W'(i) >= ptr_q);
            end
            upper_req = in_valid & upper_mask;
            grant_any = |in_valid;
            grant_idx = (|upper_req) ? lowest_idx(upper_req) : lowest_idx(in_valid);
         end

         always_comb begin
            ptr_d = ptr_q;
            if (xfer) begin
               ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ptr_q <= '0;
            end else begin
               ptr_q <= ptr_d;
            end
         end
      end
   endgenerate

   always_comb begin
      grant_oh   = '0;
      grant_word = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (grant_any && grant_idx == SEL_W'(i)) begin
            grant_oh[i] = 1'b1;
            grant_word  = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // in_ready is forced low while reset is asserted, even though space is high.
   assign in_ready = rst_n ? (grant_oh & {CHANNELS{space}}) : '0;
   assign xfer     = rst_n & grant_any & space;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (space) begin
         out_valid <= grant_any;
         if (grant_any) begin
            out_data <= grant_word;
            out_sel  <= grant_idx;
         end
      end
   end

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: four instances (direct, priority, round-robin, 3-channel direct)
// checked by directed scenarios and a random run against a behavioural model.
module tb_stream_mux;

   logic        clk;
   logic        rst_n;
   logic [1:0]  sel;
   logic [63:0] in_data;
   logic [3:0]  in_valid;
   logic        out_ready;

   logic [3:0]  rdy_dir, rdy_pri, rdy_rr;
   logic [2:0]  rdy_d3;
   logic [15:0] odata_dir, odata_pri, odata_rr, odata_d3;
   logic        ovalid_dir, ovalid_pri, ovalid_rr, ovalid_d3;
   logic [1:0]  osel_dir, osel_pri, osel_rr, osel_d3;

   int n_tests = 0;
   int n_fail  = 0;

   stream_mux #(.WIDTH(16), .CHANNELS(4), .MODE(0), .SEL_W(2)) u_dir (
      .clk(clk), .rst_n(rst_n), .sel(sel), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_dir), .out_data(odata_dir), .out_valid(ovalid_dir),
      .out_ready(out_ready), .out_sel(osel_dir));

   stream_mux #(.WIDTH(16), .CHANNELS(4), .MODE(1), .SEL_W(2)) u_pri (
      .clk(clk), .rst_n(rst_n), .sel(sel), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_pri), .out_data(odata_pri), .out_valid(ovalid_pri),
      .out_ready(out_ready), .out_sel(osel_pri));

   stream_mux #(.WIDTH(16), .CHANNELS(4), .MODE(2), .SEL_W(2)) u_rr (
      .clk(clk), .rst_n(rst_n), .sel(sel), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy_rr), .out_data(odata_rr), .out_valid(ovalid_rr),
      .out_ready(out_ready), .out_sel(osel_rr));

   stream_mux #(.WIDTH(16), .CHANNELS(3), .MODE(0), .SEL_W(2)) u_d3 (
      .clk(clk), .rst_n(rst_n), .sel(sel), .in_data(in_data[47:0]),
      .in_valid(in_valid[2:0]), .in_ready(rdy_d3), .out_data(odata_d3),
      .out_valid(ovalid_d3), .out_ready(out_ready), .out_sel(osel_d3));

   logic [3:0]  act_rdy   [4];
   logic [15:0] act_data  [4];
   logic        act_valid [4];
   logic [1:0]  act_sel   [4];

   assign act_rdy[0] = rdy_dir;
   assign act_rdy[1] = rdy_pri;
   assign act_rdy[2] = rdy_rr;
   assign act_rdy[3] = {1'b0, rdy_d3};
   assign act_data[0] = odata_dir;
   assign act_data[1] = odata_pri;
   assign act_data[2] = odata_rr;
   assign act_data[3] = odata_d3;
   assign act_valid[0] = ovalid_dir;
   assign act_valid[1] = ovalid_pri;
   assign act_valid[2] = ovalid_rr;
   assign act_valid[3] = ovalid_d3;
   assign act_sel[0] = osel_dir;
   assign act_sel[1] = osel_pri;
   assign act_sel[2] = osel_rr;
   assign act_sel[3] = osel_d3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one output slot per instance plus a round-robin pointer.
   logic        m_valid [4];
   logic [15:0] m_data  [4];
   logic [1:0]  m_sel   [4];
   int          m_ptr   [4];

   function automatic int mode_of(int k);
      case (k)
         1:       return 1;
         2:       return 2;
         default: return 0;
      endcase
   endfunction

   function automatic int ch_of(int k);
      return (k == 3) ? 3 : 4;
   endfunction

   function automatic int grant_of(int k);
      int ch;
      int g;
      ch = ch_of(k);
      g  = -1;
      case (mode_of(k))
         0: if (int'(sel) < ch && in_valid[sel]) g = int'(sel);
         1: for (int i = ch - 1; i >= 0; i--) if (in_valid[i]) g = i;
         default:
            for (int j = ch - 1; j >= 0; j--)
               if (in_valid[(m_ptr[k] + j) % ch]) g = (m_ptr[k] + j) % ch;
      endcase
      return g;
   endfunction

   function automatic logic [3:0] exp_ready(int k);
      logic [3:0] r;
      int g;
      r = 4'b0000;
      g = grant_of(k);
      if (rst_n && g >= 0 && (!m_valid[k] || out_ready)) r[g] = 1'b1;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            m_valid[k] <= 1'b0;
            m_data[k]  <= 16'h0;
            m_sel[k]   <= 2'd0;
            m_ptr[k]   <= 0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            int g;
            g = grant_of(k);
            if (!m_valid[k] || out_ready) begin
               if (g >= 0) begin
                  m_valid[k] <= 1'b1;
                  m_data[k]  <= in_data[g*16 +: 16];
                  m_sel[k]   <= 2'(g);
                  if (mode_of(k) == 2) m_ptr[k] <= (g + 1) % ch_of(k);
               end else begin
                  m_valid[k] <= 1'b0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 4'b0000;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      in_valid = 4'hf; out_ready = 1'b1; sel = 2'd0;
      in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      #1;
      n_tests++; if (rdy_dir !== 4'b0) begin n_fail++; $display("FAIL reset_rdy_dir: got %b exp 0000", rdy_dir); end
      n_tests++; if (rdy_pri !== 4'b0) begin n_fail++; $display("FAIL reset_rdy_pri: got %b exp 0000", rdy_pri); end
      n_tests++; if (rdy_rr !== 4'b0) begin n_fail++; $display("FAIL reset_rdy_rr: got %b exp 0000", rdy_rr); end
      n_tests++; if (rdy_d3 !== 3'b0) begin n_fail++; $display("FAIL reset_rdy_d3: got %b exp 000", rdy_d3); end
      tick();
      rst_n = 1'b1;
      tick();
      n_tests++; if (ovalid_rr !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b exp 1", ovalid_rr); end
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++; if (ovalid_rr !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b exp 0", ovalid_rr); end
      n_tests++; if (odata_rr !== 16'h0) begin n_fail++; $display("FAIL async_data: got %h exp 0000", odata_rr); end
      n_tests++; if (osel_rr !== 2'd0) begin n_fail++; $display("FAIL async_sel: got %0d exp 0", osel_rr); end
      n_tests++; if (odata_pri !== 16'h0) begin n_fail++; $display("FAIL async_data_pri: got %h exp 0000", odata_pri); end
      n_tests++; if (rdy_rr !== 4'b0) begin n_fail++; $display("FAIL async_rdy: got %b exp 0000", rdy_rr); end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_direct();
      in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      in_valid = 4'hf; sel = 2'd2; out_ready = 1'b1;
      #1;
      n_tests++; if (rdy_dir !== 4'b0100) begin n_fail++; $display("FAIL dir_rdy_sel2: got %b exp 0100", rdy_dir); end
      n_tests++; if (rdy_d3 !== 3'b100) begin n_fail++; $display("FAIL d3_rdy_sel2: got %b exp 100", rdy_d3); end
      tick();
      n_tests++; if (odata_dir !== 16'h3333) begin n_fail++; $display("FAIL dir_data_sel2: got %h exp 3333", odata_dir); end
      n_tests++; if (osel_dir !== 2'd2) begin n_fail++; $display("FAIL dir_sel2: got %0d exp 2", osel_dir); end
      sel = 2'd3;
      #1;
      n_tests++; if (rdy_d3 !== 3'b000) begin n_fail++; $display("FAIL d3_rdy_sel3: got %b exp 000", rdy_d3); end
      tick();
      n_tests++; if (odata_dir !== 16'h4444) begin n_fail++; $display("FAIL dir_data_sel3: got %h exp 4444", odata_dir); end
      n_tests++; if (osel_dir !== 2'd3) begin n_fail++; $display("FAIL dir_sel3: got %0d exp 3", osel_dir); end
      n_tests++; if (ovalid_d3 !== 1'b0) begin n_fail++; $display("FAIL d3_valid_drop: got %b exp 0", ovalid_d3); end
      n_tests++; if (odata_d3 !== 16'h3333) begin n_fail++; $display("FAIL d3_data_hold: got %h exp 3333", odata_d3); end
      n_tests++; if (osel_d3 !== 2'd2) begin n_fail++; $display("FAIL d3_sel_hold: got %0d exp 2", osel_d3); end
   endtask

   task automatic test_priority();
      in_valid = 4'b1010; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_tests++; if (rdy_pri !== 4'b0010) begin n_fail++; $display("FAIL pri_rdy[%0d]: got %b exp 0010", i, rdy_pri); end
         tick();
         n_tests++; if (osel_pri !== 2'd1 || odata_pri !== 16'h2222) begin
            n_fail++; $display("FAIL pri_win[%0d]: got sel %0d data %h exp sel 1 data 2222", i, osel_pri, odata_pri);
         end
      end
      in_valid = 4'b1000;
      #1;
      n_tests++; if (rdy_pri !== 4'b1000) begin n_fail++; $display("FAIL pri_rdy_ch3: got %b exp 1000", rdy_pri); end
      tick();
      n_tests++; if (osel_pri !== 2'd3 || odata_pri !== 16'h4444) begin
         n_fail++; $display("FAIL pri_ch3: got sel %0d data %h exp sel 3 data 4444", osel_pri, odata_pri);
      end
   endtask

   task automatic test_round_robin();
      int seq_a [6];
      int seq_b [4];
      seq_a = '{0, 1, 2, 3, 0, 1};
      seq_b = '{3, 0, 3, 0};
      do_reset();
      in_valid = 4'hf; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_tests++; if (ovalid_rr !== 1'b1 || osel_rr !== 2'(seq_a[i])) begin
            n_fail++; $display("FAIL rr_all[%0d]: got valid %b sel %0d exp valid 1 sel %0d", i, ovalid_rr, osel_rr, seq_a[i]);
         end
      end
      do_reset();
      in_valid = 4'b0001;
      tick();
      in_valid = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++; if (ovalid_rr !== 1'b1 || osel_rr !== 2'(seq_b[i])) begin
            n_fail++; $display("FAIL rr_1001[%0d]: got valid %b sel %0d exp valid 1 sel %0d", i, ovalid_rr, osel_rr, seq_b[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      in_data[15:0] = 16'hA0A0; in_valid = 4'b0001; out_ready = 1'b1;
      tick();
      n_tests++; if (odata_pri !== 16'hA0A0) begin n_fail++; $display("FAIL bp_first: got %h exp a0a0", odata_pri); end
      in_data[15:0] = 16'hB0B0; out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_tests++; if (rdy_pri !== 4'b0) begin n_fail++; $display("FAIL bp_rdy[%0d]: got %b exp 0000", i, rdy_pri); end
         tick();
         n_tests++; if (odata_pri !== 16'hA0A0 || ovalid_pri !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got data %h valid %b exp data a0a0 valid 1", i, odata_pri, ovalid_pri);
         end
      end
      out_ready = 1'b1;
      #1;
      n_tests++; if (rdy_pri !== 4'b0001) begin n_fail++; $display("FAIL bp_release_rdy: got %b exp 0001", rdy_pri); end
      tick();
      n_tests++; if (odata_pri !== 16'hB0B0 || ovalid_pri !== 1'b1 || osel_pri !== 2'd0) begin
         n_fail++; $display("FAIL bp_reload: got data %h valid %b sel %0d exp b0b0 1 0", odata_pri, ovalid_pri, osel_pri);
      end
   endtask

   task automatic test_drain();
      do_reset();
      in_data[47:32] = 16'hC2C2; in_valid = 4'b0100; out_ready = 1'b1;
      tick();
      n_tests++; if (ovalid_rr !== 1'b1 || odata_rr !== 16'hC2C2 || osel_rr !== 2'd2) begin
         n_fail++; $display("FAIL drain_load: got valid %b data %h sel %0d exp 1 c2c2 2", ovalid_rr, odata_rr, osel_rr);
      end
      in_valid = 4'b0000;
      tick();
      n_tests++; if (ovalid_rr !== 1'b0 || odata_rr !== 16'hC2C2) begin
         n_fail++; $display("FAIL drain_empty: got valid %b data %h exp 0 c2c2", ovalid_rr, odata_rr);
      end
      tick();
      n_tests++; if (ovalid_rr !== 1'b0) begin n_fail++; $display("FAIL drain_stay: got valid %b exp 0", ovalid_rr); end
      in_valid = 4'hf;
      #1;
      n_tests++; if (rdy_rr !== 4'b1000) begin n_fail++; $display("FAIL drain_ptr3: got %b exp 1000", rdy_rr); end
      in_valid = 4'b0000;
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_data   = {$urandom, $urandom};
         in_valid  = 4'($urandom);
         sel       = 2'($urandom);
         out_ready = ($urandom_range(3) != 0);
         #1;
         for (int k = 0; k < 4; k++) begin
            n_tests++; if (act_rdy[k] !== exp_ready(k)) begin
               n_fail++; $display("FAIL rand_rdy[%0d] inst %0d: got %b exp %b", c, k, act_rdy[k], exp_ready(k));
            end
         end
         tick();
         for (int k = 0; k < 4; k++) begin
            n_tests++; if (act_valid[k] !== m_valid[k] || act_data[k] !== m_data[k] || act_sel[k] !== m_sel[k]) begin
               n_fail++;
               $display("FAIL rand_out[%0d] inst %0d: got %b/%h/%0d exp %b/%h/%0d", c, k,
                        act_valid[k], act_data[k], act_sel[k], m_valid[k], m_data[k], m_sel[k]);
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; sel = 2'd0; in_data = '0; in_valid = 4'b0; out_ready = 1'b0;
      tick();
      tick();
      test_reset();
      test_direct();
      test_priority();
      test_round_robin();
      test_backpressure();
      test_drain();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_mux.md
Name: stream_mux

Overview:
- Parametrised, registered N-channel, W-bit multiplexer with valid/ready handshaking on every input and on the output.
- Generalises the 1-bit 2:1 select mux to wide Hack words, many channels and three selection modes: direct select, fixed priority and round-robin.
- Sits between multiple word producers (e.g. memory-mapped peripherals, CPU write paths) and a single consumer.
- One output register stage gives 1-cycle latency at full throughput.

Parameters:
- WIDTH, 16, data word width in bits (Hack word).
- CHANNELS, 4, number of input channels; legal range 2..16.
- MODE, 0, selection policy: 0 = direct (sel port chooses), 1 = fixed priority (lowest index wins), 2 = round-robin.
- SEL_W, 2, width of sel/out_sel; must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- sel  input  SEL_W  channel select, used only when MODE=0; values >= CHANNELS select nothing.
- in_data  input  CHANNELS*WIDTH  packed input words, channel i at bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel word-available flags.
- in_ready  output  CHANNELS  per-channel accept strobes.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_sel  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_sel=0, round-robin pointer=0. All in_ready are 0 while rst_n is low. Reset mid-transfer discards the held word.
- space = ~out_valid | out_ready (combinational). The output register can load this cycle when space=1.
- Grant (combinational, at most one-hot):
  - MODE 0: grant[sel] = in_valid[sel]. If sel >= CHANNELS, there is no grant.
  - MODE 1: grant goes to the lowest index i with in_valid[i]=1.
  - MODE 2: grant goes to the first i with in_valid[i]=1, searching ptr, ptr+1, … modulo CHANNELS.
- in_ready[i] = grant[i] & space. in_ready never depends on in_valid of the same channel except through grant. No combinational path from out_ready to out_data.
- Transfer on channel i occurs when in_valid[i] & in_ready[i]. At the next edge:
  - out_data <= word i; out_sel <= i; out_valid <= 1.
  - MODE 2 only: ptr <= (i+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
- When space=1 and there is no grant: out_valid <= 0 at the next edge. out_data and out_sel hold their last values.
- When out_valid=1 and out_ready=0: out_data, out_sel and out_valid hold; all in_ready=0.
- Simultaneous consume and load (out_valid=1, out_ready=1, grant present): the new word replaces the old one in the same edge. There is no bubble, so throughput is 1 word/cycle.
- Latency is 1 cycle from an input transfer to out_valid.
- ptr advances only on a transfer. It is unchanged on idle and stall cycles, and is unused in MODE 0/1.
- sel may change any cycle. It is sampled only through the combinational grant, with no stickiness.
- Protocol: producers must hold data stable while valid and not ready. The block does not check this.

Test Plan:
- Reset/idle: rst_n=0 asynchronously mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately; all in_ready=0 until release.
- MODE 0 direct: in_valid=4'b1111, words 0x1111/0x2222/0x3333/0x4444, sel=2, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0x3333, out_sel=2. Then sel=3 -> 0x4444. Set CHANNELS=3 with sel=3 -> no grant, out_valid drops.
- MODE 1 priority: in_valid=4'b1010 held, out_ready=1 -> channel 1 granted every cycle and channel 3 starves. Drop in_valid[1] -> channel 3 is granted on the next cycle.
- MODE 2 round-robin: all four valid continuously, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 over consecutive cycles with out_valid=1 every cycle (wrap checked). With in_valid=4'b1001 starting at ptr=1 -> sequence 3,0,3,0.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with in_valid[0]=1 -> out_data stable, in_ready=0. Raise out_ready -> the pending word is consumed and the channel 0 word loads on the same edge.
- Drain: single word on channel 2, then in_valid=0, out_ready=1 -> out_valid high for exactly one cycle, then 0, with out_data retaining the word and ptr=3.
